nvme_host_lite_arb: RTL and testbench

Two-requester AXI-Lite arbiter that shares the single NVMe host register slave port (`host_s_axi_*` of `nvme_host_wrap`) between the action datapath (requester 0) and the MMIO/PSL path (requester 1). It serialises accesses so that exactly one read or write is in flight at a time. Arbitration between requesters is round-robin, and responses are routed back to the granted requester. It sits directly upstream of `nvme_host_wrap`, in the same `axi_aclk` domain.

---
 rtl/nvme_host_lite_arb_pkg.sv | 19 +
 rtl/nvme_host_lite_arb_rr_arb2.sv | 25 ++
 rtl/nvme_host_lite_arb.sv | 193 +++++++++++++++++++
 tb/tb_nvme_host_lite_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvme_host_lite_arb_pkg.sv
// Shared types and constants for the NVMe host register-port arbiter.
`ifndef HOST_ADDR_BITS
`define HOST_ADDR_BITS 32
`endif

package nvme_host_lite_arb_pkg;

    typedef logic [2:0] lite_arb_state_t;

    localparam lite_arb_state_t ST_IDLE    = 3'd0;
    localparam lite_arb_state_t ST_WR      = 3'd1;
    localparam lite_arb_state_t ST_WR_RESP = 3'd2;
    localparam lite_arb_state_t ST_RD      = 3'd3;
    localparam lite_arb_state_t ST_RD_RESP = 3'd4;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/nvme_host_lite_arb_rr_arb2.sv
// Two-way round-robin selector; a tie goes to the requester that was not granted last.
module nvme_host_lite_arb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic       o_grant,
    output logic       o_grant_valid
);

    logic r_last_grant;

    assign o_grant       = (&i_req) ? ~r_last_grant : i_req[1];
    assign o_grant_valid = i_en & (|i_req);

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (o_grant_valid) begin
            r_last_grant <= o_grant;
        end
    end

endmodule

// File: rtl/nvme_host_lite_arb.sv
// Serialises two AXI-Lite requesters onto the single NVMe host register port,
// one read or write in flight at a time, round-robin between requesters.
module nvme_host_lite_arb
    import nvme_host_lite_arb_pkg::*;
#(
    parameter int ADDR_BITS = `HOST_ADDR_BITS
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,

    input  logic [ADDR_BITS-1:0] s0_axi_awaddr,
    input  logic                 s0_axi_awvalid,
    output logic                 s0_axi_awready,
    input  logic [31:0]          s0_axi_wdata,
    input  logic [3:0]           s0_axi_wstrb,
    input  logic                 s0_axi_wvalid,
    output logic                 s0_axi_wready,
    output logic [1:0]           s0_axi_bresp,
    output logic                 s0_axi_bvalid,
    input  logic                 s0_axi_bready,
    input  logic [ADDR_BITS-1:0] s0_axi_araddr,
    input  logic                 s0_axi_arvalid,
    output logic                 s0_axi_arready,
    output logic [31:0]          s0_axi_rdata,
    output logic [1:0]           s0_axi_rresp,
    output logic                 s0_axi_rvalid,
    input  logic                 s0_axi_rready,

    input  logic [ADDR_BITS-1:0] s1_axi_awaddr,
    input  logic                 s1_axi_awvalid,
    output logic                 s1_axi_awready,
    input  logic [31:0]          s1_axi_wdata,
    input  logic [3:0]           s1_axi_wstrb,
    input  logic                 s1_axi_wvalid,
    output logic                 s1_axi_wready,
    output logic [1:0]           s1_axi_bresp,
    output logic                 s1_axi_bvalid,
    input  logic                 s1_axi_bready,
    input  logic [ADDR_BITS-1:0] s1_axi_araddr,
    input  logic                 s1_axi_arvalid,
    output logic                 s1_axi_arready,
    output logic [31:0]          s1_axi_rdata,
    output logic [1:0]           s1_axi_rresp,
    output logic                 s1_axi_rvalid,
    input  logic                 s1_axi_rready,

    output logic [ADDR_BITS-1:0] m_axi_awaddr,
    output logic                 m_axi_awvalid,
    input  logic                 m_axi_awready,
    output logic [31:0]          m_axi_wdata,
    output logic [3:0]           m_axi_wstrb,
    output logic                 m_axi_wvalid,
    input  logic                 m_axi_wready,
    input  logic [1:0]           m_axi_bresp,
    input  logic                 m_axi_bvalid,
    output logic                 m_axi_bready,
    output logic [ADDR_BITS-1:0] m_axi_araddr,
    output logic                 m_axi_arvalid,
    input  logic                 m_axi_arready,
    input  logic [31:0]          m_axi_rdata,
    input  logic [1:0]           m_axi_rresp,
    input  logic                 m_axi_rvalid,
    output logic                 m_axi_rready,

    output logic                 busy,
    output logic                 grant
);

    lite_arb_state_t r_state;
    logic            r_grant;
    logic            r_aw_done;
    logic            r_w_done;

    logic w_arb_grant;
    logic w_arb_valid;
    logic w_arb_is_wr;
    logic w_idle, w_wr, w_wr_resp, w_rd, w_rd_resp;
    logic w_sel0, w_sel1;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    logic [ADDR_BITS-1:0] w_g_awaddr;
    logic [ADDR_BITS-1:0] w_g_araddr;
    logic [31:0]          w_g_wdata;
    logic [3:0]           w_g_wstrb;
    logic                 w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;

    nvme_host_lite_arb_rr_arb2 u_rr_arb2 (
        .clk           (axi_aclk),
        .rst_n         (axi_aresetn),
        .i_en          (w_idle),
        .i_req         ({s1_axi_awvalid | s1_axi_arvalid, s0_axi_awvalid | s0_axi_arvalid}),
        .o_grant       (w_arb_grant),
        .o_grant_valid (w_arb_valid)
    );

    assign w_arb_is_wr = w_arb_grant ? s1_axi_awvalid : s0_axi_awvalid;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_wr      = (r_state == ST_WR);
    assign w_wr_resp = (r_state == ST_WR_RESP);
    assign w_rd      = (r_state == ST_RD);
    assign w_rd_resp = (r_state == ST_RD_RESP);
    assign w_sel0    = ~r_grant;
    assign w_sel1    = r_grant;

    assign w_g_awaddr  = r_grant ? s1_axi_awaddr  : s0_axi_awaddr;
    assign w_g_awvalid = r_grant ? s1_axi_awvalid : s0_axi_awvalid;
    assign w_g_wdata   = r_grant ? s1_axi_wdata   : s0_axi_wdata;
    assign w_g_wstrb   = r_grant ? s1_axi_wstrb   : s0_axi_wstrb;
    assign w_g_wvalid  = r_grant ? s1_axi_wvalid  : s0_axi_wvalid;
    assign w_g_bready  = r_grant ? s1_axi_bready  : s0_axi_bready;
    assign w_g_araddr  = r_grant ? s1_axi_araddr  : s0_axi_araddr;
    assign w_g_arvalid = r_grant ? s1_axi_arvalid : s0_axi_arvalid;
    assign w_g_rready  = r_grant ? s1_axi_rready  : s0_axi_rready;

    // Every field is qualified by state so reset and idle drive all-zero outputs.
    assign m_axi_awaddr  = w_wr ? w_g_awaddr : '0;
    assign m_axi_awvalid = w_wr & ~r_aw_done & w_g_awvalid;
    assign m_axi_wdata   = w_wr ? w_g_wdata : '0;
    assign m_axi_wstrb   = w_wr ? w_g_wstrb : '0;
    assign m_axi_wvalid  = w_wr & ~r_w_done & w_g_wvalid;
    assign m_axi_bready  = w_wr_resp & w_g_bready;
    assign m_axi_araddr  = w_rd ? w_g_araddr : '0;
    assign m_axi_arvalid = w_rd & w_g_arvalid;
    assign m_axi_rready  = w_rd_resp & w_g_rready;

    assign s0_axi_awready = w_wr & w_sel0 & ~r_aw_done & m_axi_awready;
    assign s0_axi_wready  = w_wr & w_sel0 & ~r_w_done & m_axi_wready;
    assign s0_axi_bvalid  = w_wr_resp & w_sel0 & m_axi_bvalid;
    assign s0_axi_bresp   = (w_wr_resp & w_sel0) ? m_axi_bresp : AXI_RESP_OKAY;
    assign s0_axi_arready = w_rd & w_sel0 & m_axi_arready;
    assign s0_axi_rvalid  = w_rd_resp & w_sel0 & m_axi_rvalid;
    assign s0_axi_rdata   = (w_rd_resp & w_sel0) ? m_axi_rdata : '0;
    assign s0_axi_rresp   = (w_rd_resp & w_sel0) ? m_axi_rresp : AXI_RESP_OKAY;

    assign s1_axi_awready = w_wr & w_sel1 & ~r_aw_done & m_axi_awready;
    assign s1_axi_wready  = w_wr & w_sel1 & ~r_w_done & m_axi_wready;
    assign s1_axi_bvalid  = w_wr_resp & w_sel1 & m_axi_bvalid;
    assign s1_axi_bresp   = (w_wr_resp & w_sel1) ? m_axi_bresp : AXI_RESP_OKAY;
    assign s1_axi_arready = w_rd & w_sel1 & m_axi_arready;
    assign s1_axi_rvalid  = w_rd_resp & w_sel1 & m_axi_rvalid;
    assign s1_axi_rdata   = (w_rd_resp & w_sel1) ? m_axi_rdata : '0;
    assign s1_axi_rresp   = (w_rd_resp & w_sel1) ? m_axi_rresp : AXI_RESP_OKAY;

    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid & m_axi_wready;
    assign w_b_hs  = m_axi_bvalid & m_axi_bready;
    assign w_ar_hs = m_axi_arvalid & m_axi_arready;
    assign w_r_hs  = m_axi_rvalid & m_axi_rready;

    assign busy  = ~w_idle;
    assign grant = r_grant;

    // AW and W complete independently; the sticky flags mask a finished channel.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_valid) begin
                        r_grant <= w_arb_grant;
                        r_state <= w_arb_is_wr ? ST_WR : ST_RD;
                    end
                end
                ST_WR: begin
                    if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= ST_WR_RESP;
                    end else begin
                        r_aw_done <= r_aw_done | w_aw_hs;
                        r_w_done  <= r_w_done | w_w_hs;
                    end
                end
                ST_WR_RESP: begin
                    if (w_b_hs) r_state <= ST_IDLE;
                end
                ST_RD: begin
                    if (w_ar_hs) r_state <= ST_RD_RESP;
                end
                ST_RD_RESP: begin
                    if (w_r_hs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nvme_host_lite_arb.sv
// Directed bench for nvme_host_lite_arb with a host-port responder model
// and an in-order scoreboard of expected downstream transactions.
module tb_nvme_host_lite_arb;
    import nvme_host_lite_arb_pkg::*;

    localparam int AW = 32;

    logic clk;
    logic rst_n;
    logic sl_rst_n;

    logic [1:0][AW-1:0] s_awaddr, s_araddr;
    logic [1:0][31:0]   s_wdata;
    logic [1:0][3:0]    s_wstrb;
    logic [1:0]         s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
    wire  [1:0]         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    wire  [1:0][1:0]    s_bresp, s_rresp;
    wire  [1:0][31:0]   s_rdata;

    wire  [AW-1:0] m_awaddr, m_araddr;
    wire  [31:0]   m_wdata;
    wire  [3:0]    m_wstrb;
    wire           m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic          m_awready, m_wready, m_arready;
    logic          m_bvalid, m_rvalid;
    logic [1:0]    m_bresp, m_rresp;
    logic [31:0]   m_rdata;
    wire           busy, grant;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          wr;
        bit          id;
        logic [AW-1:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    nvme_host_lite_arb #(.ADDR_BITS(AW)) dut (
        .axi_aclk       (clk),
        .axi_aresetn    (rst_n),
        .s0_axi_awaddr  (s_awaddr[0]),  .s0_axi_awvalid (s_awvalid[0]), .s0_axi_awready (s_awready[0]),
        .s0_axi_wdata   (s_wdata[0]),   .s0_axi_wstrb   (s_wstrb[0]),   .s0_axi_wvalid  (s_wvalid[0]),
        .s0_axi_wready  (s_wready[0]),  .s0_axi_bresp   (s_bresp[0]),   .s0_axi_bvalid  (s_bvalid[0]),
        .s0_axi_bready  (s_bready[0]),  .s0_axi_araddr  (s_araddr[0]),  .s0_axi_arvalid (s_arvalid[0]),
        .s0_axi_arready (s_arready[0]), .s0_axi_rdata   (s_rdata[0]),   .s0_axi_rresp   (s_rresp[0]),
        .s0_axi_rvalid  (s_rvalid[0]),  .s0_axi_rready  (s_rready[0]),
        .s1_axi_awaddr  (s_awaddr[1]),  .s1_axi_awvalid (s_awvalid[1]), .s1_axi_awready (s_awready[1]),
        .s1_axi_wdata   (s_wdata[1]),   .s1_axi_wstrb   (s_wstrb[1]),   .s1_axi_wvalid  (s_wvalid[1]),
        .s1_axi_wready  (s_wready[1]),  .s1_axi_bresp   (s_bresp[1]),   .s1_axi_bvalid  (s_bvalid[1]),
        .s1_axi_bready  (s_bready[1]),  .s1_axi_araddr  (s_araddr[1]),  .s1_axi_arvalid (s_arvalid[1]),
        .s1_axi_arready (s_arready[1]), .s1_axi_rdata   (s_rdata[1]),   .s1_axi_rresp   (s_rresp[1]),
        .s1_axi_rvalid  (s_rvalid[1]),  .s1_axi_rready  (s_rready[1]),
        .m_axi_awaddr   (m_awaddr),     .m_axi_awvalid  (m_awvalid),    .m_axi_awready  (m_awready),
        .m_axi_wdata    (m_wdata),      .m_axi_wstrb    (m_wstrb),      .m_axi_wvalid   (m_wvalid),
        .m_axi_wready   (m_wready),     .m_axi_bresp    (m_bresp),      .m_axi_bvalid   (m_bvalid),
        .m_axi_bready   (m_bready),     .m_axi_araddr   (m_araddr),     .m_axi_arvalid  (m_arvalid),
        .m_axi_arready  (m_arready),    .m_axi_rdata    (m_rdata),      .m_axi_rresp    (m_rresp),
        .m_axi_rvalid   (m_rvalid),     .m_axi_rready   (m_rready),
        .busy           (busy),
        .grant          (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    function automatic logic [31:0] rd_model(input logic [AW-1:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input bit wr, input bit id, input logic [AW-1:0] addr, input logic [31:0] data);
        exp_t e;
        e.wr = wr; e.id = id; e.addr = addr; e.data = data;
        exp_q.push_back(e);
    endtask

    // Host-port responder: B one cycle after AW+W complete, R one cycle after AR.
    // Kept out of the DUT reset so a response stranded by reset stays visible.
    logic          sl_aw, sl_w;
    logic [AW-1:0] sl_addr;
    always @(posedge clk or negedge sl_rst_n) begin
        if (!sl_rst_n) begin
            sl_aw <= 1'b0; sl_w <= 1'b0; sl_addr <= '0;
            m_bvalid <= 1'b0; m_bresp <= 2'b00;
            m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= 2'b00;
        end else begin
            logic          aw_n, w_n;
            logic [AW-1:0] addr_n;
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            aw_n   = sl_aw | (m_awvalid & m_awready);
            w_n    = sl_w | (m_wvalid & m_wready);
            addr_n = (m_awvalid && m_awready) ? m_awaddr : sl_addr;
            sl_addr <= addr_n;
            if (aw_n && w_n) begin
                m_bvalid <= 1'b1;
                m_bresp  <= (addr_n == AW'('hEE)) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                sl_aw <= 1'b0; sl_w <= 1'b0;
            end else begin
                sl_aw <= aw_n; sl_w <= w_n;
            end
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= rd_model(m_araddr);
                m_rresp  <= AXI_RESP_OKAY;
            end
        end
    end

    // Downstream scoreboard and response-routing monitor.
    bit mon_aw = 0, mon_w = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_awvalid && m_awready) begin
                chk("aw_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    chk("aw_is_write", 64'(exp_q[0].wr), 64'd1);
                    chk("aw_addr", 64'(m_awaddr), 64'(exp_q[0].addr));
                    chk("aw_grant", 64'(grant), 64'(exp_q[0].id));
                end
                mon_aw = 1;
            end
            if (m_wvalid && m_wready) begin
                chk("w_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) chk("wdata", 64'(m_wdata), 64'(exp_q[0].data));
                mon_w = 1;
            end
            if (mon_aw && mon_w) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                mon_aw = 0; mon_w = 0;
            end
            if (m_arvalid && m_arready) begin
                chk("ar_queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    chk("ar_is_read", 64'(exp_q[0].wr), 64'd0);
                    chk("ar_addr", 64'(m_araddr), 64'(exp_q[0].addr));
                    chk("ar_grant", 64'(grant), 64'(exp_q[0].id));
                    void'(exp_q.pop_front());
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (s_rvalid[i]) chk("rvalid_route", 64'(grant), 64'(i));
                if (s_bvalid[i]) chk("bvalid_route", 64'(grant), 64'(i));
            end
        end
    end

    task automatic do_write(input int id, input logic [AW-1:0] addr, input logic [31:0] data,
                            input int wdly, input logic [1:0] eresp);
        bit aw_ok, w_ok, ok;
        int n;
        s_awaddr[id] = addr; s_wdata[id] = data; s_wstrb[id] = 4'hF;
        s_awvalid[id] = 1'b1; s_wvalid[id] = (wdly == 0); s_bready[id] = 1'b1;
        aw_ok = 0; w_ok = 0; n = 0;
        while (!(aw_ok && w_ok) && n < 200) begin
            @(negedge clk);
            if (s_awvalid[id] && s_awready[id]) aw_ok = 1;
            if (s_wvalid[id] && s_wready[id]) w_ok = 1;
            @(posedge clk); #1;
            if (aw_ok) s_awvalid[id] = 1'b0;
            if (w_ok) s_wvalid[id] = 1'b0;
            n++;
            if (n == wdly && !w_ok) s_wvalid[id] = 1'b1;
        end
        s_awvalid[id] = 1'b0; s_wvalid[id] = 1'b0;
        chk("write_addr_data_accepted", 64'(aw_ok && w_ok), 64'd1);
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_bvalid[id]) begin
                ok = 1;
                chk("bresp", 64'(s_bresp[id]), 64'(eresp));
            end
            @(posedge clk); #1;
            n++;
        end
        s_bready[id] = 1'b0;
        chk("b_received", 64'(ok), 64'd1);
    endtask

    task automatic do_read(input int id, input logic [AW-1:0] addr);
        bit ok;
        int n;
        s_araddr[id] = addr; s_arvalid[id] = 1'b1; s_rready[id] = 1'b1;
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_arready[id]) ok = 1;
            @(posedge clk); #1;
            n++;
        end
        s_arvalid[id] = 1'b0;
        chk("ar_accepted", 64'(ok), 64'd1);
        ok = 0; n = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (s_rvalid[id]) begin
                ok = 1;
                chk("rdata", 64'(s_rdata[id]), 64'(rd_model(addr)));
                chk("rresp", 64'(s_rresp[id]), 64'(AXI_RESP_OKAY));
            end
            @(posedge clk); #1;
            n++;
        end
        s_rready[id] = 1'b0;
        chk("r_received", 64'(ok), 64'd1);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_m_rready", 64'(m_rready), 64'd0);
        chk("rst_s_rvalid", 64'(s_rvalid), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sl_rst_n = 1'b0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;

        // Reset state with a live-looking request on s0 inputs.
        s_awaddr[0] = 32'h1234; s_wdata[0] = 32'h5555_AAAA; s_awvalid[0] = 1'b1;
        s_araddr[1] = 32'h4321; s_arvalid[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("reset_m_awaddr", 64'(m_awaddr), 64'd0);
        chk("reset_m_wdata", 64'(m_wdata), 64'd0);
        chk("reset_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("reset_m_araddr", 64'(m_araddr), 64'd0);
        chk("reset_s_awready", 64'(s_awready), 64'd0);
        chk("reset_s_arready", 64'(s_arready), 64'd0);
        s_awvalid = '0; s_arvalid = '0; s_awaddr = '0; s_araddr = '0; s_wdata = '0;
        sl_rst_n = 1'b1; rst_n = 1'b1;
        @(posedge clk); #1;

        // Single s0 write with one-cycle grant latency.
        push(1, 0, 32'h10, 32'hDEAD_BEEF);
        fork
            do_write(0, 32'h10, 32'hDEAD_BEEF, 0, AXI_RESP_OKAY);
            begin
                @(negedge clk);
                chk("t1_no_comb_awvalid", 64'(m_awvalid), 64'd0);
                @(negedge clk);
                chk("t1_m_awvalid", 64'(m_awvalid), 64'd1);
                chk("t1_m_awaddr", 64'(m_awaddr), 64'h10);
                chk("t1_m_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
                chk("t1_busy", 64'(busy), 64'd1);
            end
        join
        chk("t1_busy_after_b", 64'(busy), 64'd0);

        // Simultaneous reads right after reset: s0 first.
        pulse_reset();
        push(0, 0, 32'h20, 32'h0);
        push(0, 1, 32'h24, 32'h0);
        fork
            do_read(0, 32'h20);
            do_read(1, 32'h24);
        join

        // Continuous contention: grants alternate 0,1,0,1...
        for (int i = 0; i < 4; i++) begin
            push(1, 0, AW'(32'h100 + i * 4), 32'hA000_0000 + i);
            push(0, 1, AW'(32'h200 + i * 4), 32'h0);
        end
        fork
            for (int i = 0; i < 4; i++) do_write(0, AW'(32'h100 + i * 4), 32'hA000_0000 + i, 0, AXI_RESP_OKAY);
            for (int j = 0; j < 4; j++) do_read(1, AW'(32'h200 + j * 4));
        join

        // s1 AW early, W five cycles later; s0 held off meanwhile.
        push(1, 1, 32'hEE, 32'h1111_2222);
        push(1, 0, 32'h44, 32'h3333_4444);
        fork
            do_write(1, 32'hEE, 32'h1111_2222, 5, AXI_RESP_SLVERR);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_write(0, 32'h44, 32'h3333_4444, 0, AXI_RESP_OKAY);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                chk("t4_awvalid_c1", 64'(m_awvalid), 64'd1);
                chk("t4_wvalid_c1", 64'(m_wvalid), 64'd0);
                @(negedge clk);
                chk("t4_awvalid_masked", 64'(m_awvalid), 64'd0);
                chk("t4_s0_awready_held", 64'(s_awready[0]), 64'd0);
                chk("t4_busy", 64'(busy), 64'd1);
                @(negedge clk);
                @(negedge clk);
                chk("t4_wvalid_c4", 64'(m_wvalid), 64'd0);
                @(negedge clk);
                chk("t4_wvalid_c5", 64'(m_wvalid), 64'd1);
                chk("t4_s1_wready_c5", 64'(s_wready[1]), 64'd1);
            end
        join

        // s0 write and read together: write first, then read.
        push(1, 0, 32'h50, 32'h0BAD_F00D);
        push(0, 0, 32'h54, 32'h0);
        fork
            do_write(0, 32'h50, 32'h0BAD_F00D, 0, AXI_RESP_OKAY);
            do_read(0, 32'h54);
        join

        // Reset while s1 sits in RD_RESP; stale response must not leak.
        begin
            bit seen;
            int n;
            push(0, 1, 32'h60, 32'h0);
            s_araddr[1] = 32'h60; s_arvalid[1] = 1'b1; s_rready[1] = 1'b0;
            seen = 0; n = 0;
            while (!seen && n < 50) begin
                @(negedge clk);
                if (s_rvalid[1]) seen = 1;
                else begin @(posedge clk); #1; end
                n++;
            end
            chk("t6_rd_resp_reached", 64'(seen), 64'd1);
            s_arvalid[1] = 1'b0;
            #2 rst_n = 1'b0;
            #1;
            chk("t6_async_s1_rvalid", 64'(s_rvalid[1]), 64'd0);
            chk("t6_async_s1_rdata", 64'(s_rdata[1]), 64'd0);
            chk("t6_async_busy", 64'(busy), 64'd0);
            chk("t6_async_m_rready", 64'(m_rready), 64'd0);
            chk("t6_async_grant", 64'(grant), 64'd0);
            @(posedge clk); #1 rst_n = 1'b1;
            @(negedge clk);
            chk("t6_stale_s_rvalid", 64'(s_rvalid), 64'd0);
            chk("t6_stale_busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            push(0, 1, 32'h64, 32'h0);
            do_read(1, 32'h64);
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
